// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: default bus widths and
// the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO for fetched {pc, instruction} pairs. Clear empties it on
// the same edge; push and pop in one cycle leave the count unchanged.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & (count_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero while empty after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Issue is gated on free space and only one request is ever in flight.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            assert (count_q != (PW+1)'(DEPTH));
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one imem read at a time from the current PC,
// buffers tagged responses and presents them to decode via valid/ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_advance,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    fetch_state_t        state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [CNT_W-1:0]    fifo_count;
    logic [ENT_W-1:0]    fifo_head;
    logic                keep_fetch;
    logic                fifo_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Once raised, a request is held until ack; a flush only marks it for discard.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && (fifo_count < CNT_W'(DEPTH))) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign keep_fetch = (state_q == ST_REQ) & imem_ack & ~flush;
    assign fifo_pop   = id_valid & id_ready & ~flush;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (keep_fetch),
        .push_data ({addr_q, imem_rdata}),
        .pop       (fifo_pop),
        .clear     (flush),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign pc_advance = keep_fetch;
    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign id_valid   = (fifo_count != '0);
    assign id_pc      = fifo_head[ENT_W-1:INSTR_W];
    assign id_instr   = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for steady-state fetch plus
// hand-written flush and reset sequences.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc_in;
    logic        pc_advance;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [15:0] id_instr;
    logic [15:0] id_pc;

    int checks = 0;
    int failures = 0;

    // Environment: PC register, and a memory that acks after mem_wait cycles
    logic [15:0] pc_model = 16'h0000;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        mem_en = 1'b1;
    logic        man_ack = 1'b0;
    int          mem_wait = 0;
    int          wait_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_load) pc_model <= pc_load_val;
        else if (pc_advance) pc_model <= pc_model + 16'd1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    assign pc_in      = pc_model;
    assign imem_ack   = mem_en ? (imem_req && (wait_cnt == mem_wait)) : man_ack;
    assign imem_rdata = imem_addr ^ 16'h5A5A;

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    typedef struct {
        bit          rst_before;
        bit          ready;
        int          wt;
        bit          exp_req;
        logic [15:0] exp_addr;
        bit          exp_adv;
        bit          exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(bit rb, bit rdy, int wt, bit req, logic [15:0] addr,
                                bit adv, bit vld, logic [15:0] pc, logic [15:0] ins);
        vec_t v;
        v.rst_before = rb;
        v.ready      = rdy;
        v.wt         = wt;
        v.exp_req    = req;
        v.exp_addr   = addr;
        v.exp_adv    = adv;
        v.exp_valid  = vld;
        v.exp_pc     = pc;
        v.exp_instr  = ins;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Asserts reset immediately, loads the model PC, releases on a falling edge.
    task automatic do_reset(input logic [15:0] start_pc);
        rst = 1'b0;
        flush = 1'b0;
        man_ack = 1'b0;
        pc_load = 1'b1;
        pc_load_val = start_pc;
        @(negedge clk);
        @(negedge clk);
        pc_load = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait memory, decode always ready: one fetch per two cycles
        vecs[0]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h5A5A);
        vecs[3]  = mk(0, 1, 0, 1, 16'h0001, 1, 0, 16'h0000, 16'h0000);
        vecs[4]  = mk(0, 1, 0, 0, 16'h0001, 0, 1, 16'h0001, 16'h5A5B);
        vecs[5]  = mk(0, 1, 0, 1, 16'h0002, 1, 0, 16'h0000, 16'h0000);
        vecs[6]  = mk(0, 1, 0, 0, 16'h0002, 0, 1, 16'h0002, 16'h5A58);
        vecs[7]  = mk(0, 1, 0, 1, 16'h0003, 1, 0, 16'h0000, 16'h0000);
        vecs[8]  = mk(0, 1, 0, 0, 16'h0003, 0, 1, 16'h0003, 16'h5A59);
        // Decode stalled: FIFO fills with two entries, then resumes at addr 2
        vecs[9]  = mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[10] = mk(0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000);
        vecs[11] = mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h5A5A);
        vecs[12] = mk(0, 0, 0, 1, 16'h0001, 1, 1, 16'h0000, 16'h5A5A);
        vecs[13] = mk(0, 0, 0, 0, 16'h0001, 0, 1, 16'h0000, 16'h5A5A);
        vecs[14] = mk(0, 0, 0, 0, 16'h0001, 0, 1, 16'h0000, 16'h5A5A);
        vecs[15] = mk(0, 1, 0, 0, 16'h0001, 0, 1, 16'h0000, 16'h5A5A);
        vecs[16] = mk(0, 1, 0, 0, 16'h0001, 0, 1, 16'h0001, 16'h5A5B);
        vecs[17] = mk(0, 1, 0, 1, 16'h0002, 1, 0, 16'h0000, 16'h0000);
        vecs[18] = mk(0, 1, 0, 0, 16'h0002, 0, 1, 16'h0002, 16'h5A58);
        // Three wait states: request held four cycles at a constant address
        vecs[19] = mk(1, 1, 3, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[20] = mk(0, 1, 3, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[21] = mk(0, 1, 3, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[22] = mk(0, 1, 3, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[23] = mk(0, 1, 3, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000);
        vecs[24] = mk(0, 1, 3, 0, 16'h0000, 0, 1, 16'h0000, 16'h5A5A);
        vecs[25] = mk(0, 1, 3, 1, 16'h0001, 0, 0, 16'h0000, 16'h0000);

        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            if (vecs[i].rst_before) begin
                mem_en = 1'b1;
                do_reset(16'h0000);
            end
            id_ready = vecs[i].ready;
            mem_wait = vecs[i].wt;
            #1;
            check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d pc_advance", i), 32'(pc_advance), 32'(vecs[i].exp_adv));
            check($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d id_pc", i), 32'(id_pc), 32'(vecs[i].exp_pc));
                check($sformatf("v%0d id_instr", i), 32'(id_instr), 32'(vecs[i].exp_instr));
            end
            @(negedge clk);
        end

        // Flush during REQ, ack two cycles later; FIFO holds addr 5
        mem_en = 1'b1;
        mem_wait = 0;
        id_ready = 1'b0;
        do_reset(16'h0005);
        @(negedge clk);
        @(negedge clk);
        mem_en = 1'b0;
        man_ack = 1'b0;
        #1;
        check("fl pre id_valid", 32'(id_valid), 32'd1);
        check("fl pre id_pc", 32'(id_pc), 32'h0005);
        check("fl pre id_instr", 32'(id_instr), 32'h5A5F);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("fl state REQ", 32'(dut.state_q), 32'(ST_REQ));
        check("fl req addr", 32'(imem_addr), 32'h0006);
        check("fl adv0", 32'(pc_advance), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl state DRAIN", 32'(dut.state_q), 32'(ST_DRAIN));
        check("fl drain req", 32'(imem_req), 32'd1);
        check("fl drain addr", 32'(imem_addr), 32'h0006);
        check("fl cleared id_valid", 32'(id_valid), 32'd0);
        @(negedge clk);
        man_ack = 1'b1;
        #1;
        check("fl drain ack adv", 32'(pc_advance), 32'd0);
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        check("fl state IDLE", 32'(dut.state_q), 32'(ST_IDLE));
        check("fl idle req", 32'(imem_req), 32'd0);
        check("fl dropped id_valid", 32'(id_valid), 32'd0);
        check("fl pc unchanged", 32'(pc_model), 32'h0006);

        // Flush coincident with ack: response dropped, PC not advanced
        @(negedge clk);
        flush = 1'b1;
        man_ack = 1'b1;
        #1;
        check("fa req", 32'(imem_req), 32'd1);
        check("fa addr", 32'(imem_addr), 32'h0006);
        check("fa adv0", 32'(pc_advance), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        man_ack = 1'b0;
        #1;
        check("fa state IDLE", 32'(dut.state_q), 32'(ST_IDLE));
        check("fa id_valid", 32'(id_valid), 32'd0);
        check("fa pc unchanged", 32'(pc_model), 32'h0006);
        @(negedge clk);
        man_ack = 1'b1;
        #1;
        check("fa reissue addr", 32'(imem_addr), 32'h0006);
        check("fa reissue adv", 32'(pc_advance), 32'd1);
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        check("fa id_pc", 32'(id_pc), 32'h0006);
        check("fa id_instr", 32'(id_instr), 32'h5A5C);
        @(negedge clk);
        #1;
        check("rs pre req", 32'(imem_req), 32'd1);
        check("rs pre addr", 32'(imem_addr), 32'h0007);
        check("rs pre id_valid", 32'(id_valid), 32'd1);

        // Reset mid-handshake: outputs clear without a clock edge
        rst = 1'b0;
        man_ack = 1'b1;
        #1;
        check("rs req", 32'(imem_req), 32'd0);
        check("rs addr", 32'(imem_addr), 32'd0);
        check("rs id_valid", 32'(id_valid), 32'd0);
        check("rs id_pc", 32'(id_pc), 32'd0);
        check("rs id_instr", 32'(id_instr), 32'd0);
        check("rs adv", 32'(pc_advance), 32'd0);
        man_ack = 1'b0;
        mem_en = 1'b1;
        id_ready = 1'b1;
        do_reset(16'hFFFF);
        #1;
        check("rr idle req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        check("rr addr FFFF", 32'(imem_addr), 32'hFFFF);
        check("rr adv", 32'(pc_advance), 32'd1);
        @(negedge clk);
        #1;
        check("rr id_pc", 32'(id_pc), 32'hFFFF);
        check("rr id_instr", 32'(id_instr), 32'hA5A5);
        @(negedge clk);
        #1;
        check("rr wrap addr", 32'(imem_addr), 32'h0000);
        check("rr wrap req", 32'(imem_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
